// File: rtl/adder_share_pkg.sv
// ---------------------------------------------------------------------------
// adder_share_pkg : shared types and helpers for the round-robin adder share
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adder_share_pkg;

  localparam int CNTW_DEF = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  // Index width for n requesters; never below one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder : combinational WIDTH-bit adder with carry-out, no carry-in
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting at ptr_i
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idw(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  localparam logic [IW:0] C_N = (IW+1)'(N);

  logic [N-1:0] w_rot;
  logic [IW:0]  w_ofs;
  logic [IW:0]  w_sum;
  logic         w_found;

  // Rotate so that bit 0 is the requester at ptr_i; the lowest set bit wins.
  assign w_rot = (req_i >> ptr_i) | (req_i << (N - int'(ptr_i)));

  always_comb begin
    w_ofs   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_ofs   = (IW+1)'(k);
      end
    end
  end

  assign w_sum     = {1'b0, ptr_i} + w_ofs;
  assign gnt_idx_o = (w_sum >= C_N) ? IW'(w_sum - C_N) : w_sum[IW-1:0];
  assign any_o     = |req_i;
  assign gnt_o     = any_o ? (N'(1) << gnt_idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/adder_rr_share.sv
// ---------------------------------------------------------------------------
// adder_rr_share : one adder shared by NREQ requesters, round-robin granted,
//                  with a one-entry registered response stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder_rr_share
  import adder_share_pkg::*;
#(
  parameter  int WIDTH = 9,
  parameter  int NREQ  = 4,
  parameter  int CNTW  = CNTW_DEF,
  localparam int IDW   = idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_sum_o,
  output logic                  rsp_cout_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [CNTW-1:0]       op_cnt_o
);

  localparam logic [IDW-1:0] C_LAST = IDW'(NREQ - 1);

  rsp_state_e       state_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   ptr_q;
  logic [CNTW-1:0]  cnt_q;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_can_grant;
  logic             w_fire;
  logic             w_drain;
  logic [NREQ-1:0]  w_take;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .gnt_o    (w_gnt),
    .gnt_idx_o(w_idx),
    .any_o    (w_any)
  );

  // rst_n gates the grant so no requester sees ready while held in reset.
  assign w_can_grant = rst_n & ((state_q == ST_EMPTY) | rsp_ready_i);
  assign w_fire      = w_can_grant & w_any;
  assign w_take      = w_gnt & {NREQ{w_can_grant}};
  assign w_drain     = (state_q == ST_FULL) & rsp_ready_i;
  assign req_ready_o = w_take;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_a = w_a | (req_a_i[i*WIDTH +: WIDTH] & {WIDTH{w_take[i]}});
      w_b = w_b | (req_b_i[i*WIDTH +: WIDTH] & {WIDTH{w_take[i]}});
    end
  end

  adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i   (w_a),
    .b_i   (w_b),
    .sum_o (w_add_sum),
    .cout_o(w_add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (w_fire) state_q <= ST_FULL;
        ST_FULL:  if (!w_fire && rsp_ready_i) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
      if (w_fire) begin
        sum_q  <= w_add_sum;
        cout_q <= w_add_cout;
        id_q   <= w_idx;
        ptr_q  <= (w_idx == C_LAST) ? '0 : w_idx + IDW'(1);
      end
      if (w_drain) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign rsp_valid_o = (state_q == ST_FULL);
  assign rsp_sum_o   = sum_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_id_o    = id_q;
  assign op_cnt_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_share.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_share : scoreboard bench with a behavioural arbitration model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adder_rr_share;

  localparam int WIDTH = 9;
  localparam int NREQ  = 4;
  localparam int CNTW  = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;
  logic [CNTW-1:0]       op_cnt;

  adder_rr_share #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_sum_o  (rsp_sum),
    .rsp_cout_o (rsp_cout),
    .rsp_id_o   (rsp_id),
    .op_cnt_o   (op_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: one response slot, a rotating priority start, a counter.
  typedef struct { int sum; int cout; int id; } exp_t;
  exp_t            sbq[$];
  bit              m_full = 1'b0;
  int              m_ptr  = 0;
  int              m_cnt  = 0;
  logic [NREQ-1:0] m_gnt  = '0;

  always @(negedge clk) begin : p_model
    int win, c, a, b, s;
    bit cg;
    logic [NREQ-1:0] er;
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_gnt  = '0;
      sbq.delete();
    end else begin
      cg  = !m_full || rsp_ready;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[c]) win = c;
      end
      er = '0;
      if (cg && win >= 0) er[win] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(er));
      check("rsp_valid", 32'(rsp_valid), 32'(m_full));
      check("op_cnt", 32'(op_cnt), m_cnt & 32'hFFFF);
      if (m_full && rsp_ready) m_cnt++;
      m_gnt = er;
      if (er != '0) begin
        a = int'(req_a[win*WIDTH +: WIDTH]);
        b = int'(req_b[win*WIDTH +: WIDTH]);
        s = a + b;
        sbq.push_back('{s % (1 << WIDTH), s / (1 << WIDTH), win});
        m_full = 1'b1;
        m_ptr  = (win + 1) % NREQ;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (sbq.size() == 0) begin
        check("sb_depth", sbq.size(), 1);
      end else begin
        e = sbq[0];
        check("sb_sum", 32'(rsp_sum), e.sum);
        check("sb_cout", 32'(rsp_cout), e.cout);
        check("sb_id", 32'(rsp_id), e.id);
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_sum", 32'(rsp_sum), 0);
    check("rst_cout", 32'(rsp_cout), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_op_cnt", 32'(op_cnt), 0);
    req_valid = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single requester, carry boundaries
    req_valid = 4'b0001;
    set_op(0, 255, 1);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 1);
    tick();
    set_op(0, 511, 1);
    @(negedge clk);
    check("t1_sum", 32'(rsp_sum), 256);
    check("t1_cout", 32'(rsp_cout), 0);
    check("t1_id", 32'(rsp_id), 0);
    tick();
    set_op(0, 300, 400);
    @(negedge clk);
    check("t2_sum_wrap", 32'(rsp_sum), 0);
    check("t2_cout_wrap", 32'(rsp_cout), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t2_sum", 32'(rsp_sum), 188);
    check("t2_cout", 32'(rsp_cout), 1);

    // All four valid: strict rotation, back-to-back
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 511), $urandom_range(0, 511));
    req_valid = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_valid", 32'(rsp_valid), 1);
      check("t3_id", 32'(rsp_id), k % NREQ);
    end

    // Backpressure: one grant, then stall, then drain+refill
    do_reset();
    set_op(1, 100, 50);
    set_op(2, 7, 8);
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t4_first_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_stall_ready", 32'(req_ready), 0);
      check("t4_stall_id", 32'(rsp_id), 1);
      check("t4_stall_sum", 32'(rsp_sum), 150);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_refill_ready", 32'(req_ready), 32'b0100);
    check("t4_drain_id", 32'(rsp_id), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t4_next_id", 32'(rsp_id), 2);
    check("t4_next_sum", 32'(rsp_sum), 15);

    // Asynchronous reset while FULL
    do_reset();
    set_op(0, 1, 2);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    #2;
    check("t5_full", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(rsp_valid), 0);
    check("t5_async_ready", 32'(req_ready), 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_op(3, 9, 9);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_prio_ready", 32'(req_ready), 1);
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    check("t5_first_id", 32'(rsp_id), 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t5_second_id", 32'(rsp_id), 3);

    // Counter wrap
    do_reset();
    set_op(0, 3, 4);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    repeat (65536) @(negedge clk);
    check("t6_cnt_max", 32'(op_cnt), 65535);
    @(negedge clk);
    check("t6_cnt_wrap", 32'(op_cnt), 0);

    // Randomized traffic with backpressure and withdrawals
    do_reset();
    for (int n = 0; n < 400; n++) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, ($urandom_range(0, 3) == 0) ? 511 : $urandom_range(0, 511),
                 $urandom_range(0, 511));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
